// File: rtl/vending_machine_param.sv
// Parameterised vending machine controller.
// Coins are accepted up to a balance ceiling. A rising select edge vends the
// lowest-index affordable, in-stock item. Change is paid out one coin per
// cycle, either on request or after an idle timeout.
module vending_machine_param #(
   parameter int N_COINS = 3,
   parameter int N_ITEMS = 4,
   parameter logic [N_COINS*16-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
   parameter logic [N_ITEMS*16-1:0] ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400},
   parameter int TOTAL_BITS = 31,
   parameter int MAX_BALANCE = 9900,
   parameter int STOCK_INIT = 3,
   parameter int TIMEOUT = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_COINS-1:0] i_input_coin,
   input  logic [N_ITEMS-1:0] i_select_item,
   input  logic               i_trigger_return,
   input  logic               i_restock,
   output logic [N_ITEMS-1:0] o_available_item,
   output logic [N_ITEMS-1:0] o_output_item,
   output logic [N_COINS-1:0] o_return_coin,
   output logic [N_ITEMS-1:0] o_sold_out,
   output logic               o_busy
);

   localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Working width for balance arithmetic: wide enough for balance plus a
   // full handful of coins without overflow.
   localparam int WB = ((TOTAL_BITS > 16) ? TOTAL_BITS : 16) + $clog2(N_COINS + 1) + 1;

   localparam logic [SW-1:0] STOCK_FULL = SW'(STOCK_INIT);
   localparam logic [TW-1:0] TIMER_FULL = TW'(TIMEOUT);
   localparam logic [WB-1:0] MAX_BAL_W  = WB'(MAX_BALANCE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_RETURN
   } state_t;

   state_t                        state_q, state_d;
   logic [TOTAL_BITS-1:0]         balance_q, balance_d;
   logic [N_ITEMS-1:0][SW-1:0]    stock_q, stock_d;
   logic [TW-1:0]                 timer_q, timer_d;
   logic [N_ITEMS-1:0]            selPrev_q, selPrev_d;
   logic [N_ITEMS-1:0]            outputItem_q, outputItem_d;
   logic [N_COINS-1:0]            returnCoin_q, returnCoin_d;

   logic [WB-1:0]                 balanceW;
   logic [N_ITEMS-1:0]            availItem;
   logic [N_ITEMS-1:0]            soldOut;
   logic [N_ITEMS-1:0]            selRise;
   logic [N_ITEMS-1:0]            vendOneHot;
   logic                          vendFound;
   logic [WB-1:0]                 vendPrice;
   logic [WB-1:0]                 coinSum;
   logic [N_COINS-1:0]            retOneHot;
   logic                          retFound;
   logic [WB-1:0]                 retValue;
   logic [WB-1:0]                 afterVend;
   logic [WB-1:0]                 newBal;
   logic                          coinTaken;

   assign balanceW = WB'(balance_q);
   assign selRise  = i_select_item & ~selPrev_q;

   // Item availability and sold-out flags, decoded straight from registered state.
   always_comb begin
      availItem = '0;
      soldOut   = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         soldOut[i]   = (stock_q[i] == '0);
         availItem[i] = (state_q != ST_RETURN) &&
                        (balanceW >= WB'(ITEM_PRICES[i*16 +: 16])) &&
                        (stock_q[i] != '0);
      end
   end

   // Pick the lowest-index item whose select just rose and which is available.
   always_comb begin
      vendOneHot = '0;
      vendFound  = 1'b0;
      vendPrice  = '0;
      for (int i = N_ITEMS - 1; i >= 0; i--) begin
         if (selRise[i] && availItem[i]) begin
            vendOneHot    = '0;
            vendOneHot[i] = 1'b1;
            vendFound     = 1'b1;
            vendPrice     = WB'(ITEM_PRICES[i*16 +: 16]);
         end
      end
   end

   // Total value of all coins presented this cycle.
   always_comb begin
      coinSum = '0;
      for (int j = 0; j < N_COINS; j++) begin
         if (i_input_coin[j]) begin
            coinSum = coinSum + WB'(COIN_VALUES[j*16 +: 16]);
         end
      end
   end

   // Largest coin that still fits in the balance, used when paying out change.
   always_comb begin
      retOneHot = '0;
      retFound  = 1'b0;
      retValue  = '0;
      for (int j = 0; j < N_COINS; j++) begin
         if (WB'(COIN_VALUES[j*16 +: 16]) <= balanceW) begin
            retOneHot    = '0;
            retOneHot[j] = 1'b1;
            retFound     = 1'b1;
            retValue     = WB'(COIN_VALUES[j*16 +: 16]);
         end
      end
   end

   // Next-state logic: coin acceptance, vending, idle timer and change payout.
   always_comb begin
      state_d      = state_q;
      stock_d      = stock_q;
      timer_d      = timer_q;
      selPrev_d    = i_select_item;
      outputItem_d = '0;
      returnCoin_d = '0;
      afterVend    = balanceW;
      newBal       = balanceW;
      coinTaken    = 1'b0;

      case (state_q)
         ST_IDLE, ST_ACCEPT: begin
            afterVend    = balanceW - vendPrice;
            newBal       = afterVend;
            outputItem_d = vendOneHot;
            for (int i = 0; i < N_ITEMS; i++) begin
               if (vendOneHot[i] && (stock_q[i] != '0)) begin
                  stock_d[i] = stock_q[i] - SW'(1);
               end
            end
            if (i_input_coin != '0) begin
               if ((afterVend + coinSum) <= MAX_BAL_W) begin
                  newBal    = afterVend + coinSum;
                  coinTaken = 1'b1;
               end else begin
                  returnCoin_d = i_input_coin;
               end
            end
            if (coinTaken || vendFound) begin
               timer_d = TIMER_FULL;
            end else if ((state_q == ST_ACCEPT) && (timer_q != '0)) begin
               timer_d = timer_q - TW'(1);
            end
            if (newBal == '0) begin
               state_d = ST_IDLE;
            end else if ((state_q == ST_ACCEPT) && i_trigger_return) begin
               state_d = ST_RETURN;
            end else if ((state_q == ST_ACCEPT) && !coinTaken && !vendFound &&
                         (timer_q <= TW'(1))) begin
               state_d = ST_RETURN;
            end else begin
               state_d = ST_ACCEPT;
            end
         end
         ST_RETURN: begin
            timer_d      = TIMER_FULL;
            returnCoin_d = retOneHot;
            if (retFound) begin
               newBal = balanceW - retValue;
            end else begin
               newBal = '0;
            end
            state_d = (newBal == '0) ? ST_IDLE : ST_RETURN;
         end
         default: begin
            state_d = ST_IDLE;
            newBal  = '0;
         end
      endcase

      if (i_restock) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = STOCK_FULL;
         end
      end

      balance_d = newBal[TOTAL_BITS-1:0];
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         balance_q    <= '0;
         timer_q      <= TIMER_FULL;
         selPrev_q    <= '0;
         outputItem_q <= '0;
         returnCoin_q <= '0;
         for (int i = 0; i < N_ITEMS; i++) begin
            stock_q[i] <= STOCK_FULL;
         end
      end else begin
         state_q      <= state_d;
         balance_q    <= balance_d;
         timer_q      <= timer_d;
         selPrev_q    <= selPrev_d;
         outputItem_q <= outputItem_d;
         returnCoin_q <= returnCoin_d;
         stock_q      <= stock_d;
      end
   end

   assign o_available_item = availItem;
   assign o_sold_out       = soldOut;
   assign o_output_item    = outputItem_q;
   assign o_return_coin    = returnCoin_q;
   assign o_busy           = (state_q == ST_RETURN);

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed testbench for vending_machine_param at default parameters.
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] i_input_coin;
   logic [3:0] i_select_item;
   logic       i_trigger_return;
   logic       i_restock;
   logic [3:0] o_available_item;
   logic [3:0] o_output_item;
   logic [2:0] o_return_coin;
   logic [3:0] o_sold_out;
   logic       o_busy;

   int checks = 0;
   int errors = 0;
   int pulses;
   int cnt;
   logic [2:0] expSeq [8];

   vending_machine_param dut (
      .clk              (clk),
      .reset            (reset),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .i_restock        (i_restock),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_sold_out       (o_sold_out),
      .o_busy           (o_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case the bench itself gets stuck.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel,
                                input logic trig, input logic rstk);
      i_input_coin     = coin;
      i_select_item    = sel;
      i_trigger_return = trig;
      i_restock        = rstk;
      tick();
   endtask

   task automatic resetDut();
      reset = 1'b1;
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Directed scenario sequence.
   initial begin
      reset = 1'b1;
      i_input_coin = '0;
      i_select_item = '0;
      i_trigger_return = 1'b0;
      i_restock = 1'b0;
      tick();
      tick();
      checkOutput("rst_avail", 32'(o_available_item), 32'd0);
      checkOutput("rst_sold", 32'(o_sold_out), 32'd0);
      checkOutput("rst_out", 32'(o_output_item), 32'd0);
      checkOutput("rst_ret", 32'(o_return_coin), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_bal", 32'(dut.balance_q), 32'd0);
      reset = 1'b0;

      // Coin accumulation and availability thresholds.
      repeat (3) applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
      checkOutput("avail_300", 32'(o_available_item), 32'b0000);
      repeat (2) applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
      checkOutput("avail_500", 32'(o_available_item), 32'b0011);
      repeat (2) applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
      checkOutput("avail_1500", 32'(o_available_item), 32'b0111);
      repeat (4) applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      checkOutput("avail_5500", 32'(o_available_item), 32'b1111);
      checkOutput("bal_5500", 32'(dut.balance_q), 32'd5500);

      // Held select produces a single vend.
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(3'b000, 4'b0001, 1'b0, 1'b0);
         if (o_output_item != 4'b0000) pulses++;
         if (k == 0) checkOutput("hold_first", 32'(o_output_item), 32'b0001);
      end
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("hold_pulses", 32'(pulses), 32'd1);
      checkOutput("hold_bal", 32'(dut.balance_q), 32'd5100);
      checkOutput("hold_stock0", 32'(dut.stock_q[0]), 32'd2);

      // Sell out item 3, try once more, then restock.
      resetDut();
      repeat (7) applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      checkOutput("avail_7000", 32'(o_available_item), 32'b1111);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(3'b000, 4'b1000, 1'b0, 1'b0);
         checkOutput("vend3", 32'(o_output_item), 32'b1000);
         applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      end
      checkOutput("sell_bal", 32'(dut.balance_q), 32'd1000);
      checkOutput("sell_sold", 32'(o_sold_out), 32'b1000);
      checkOutput("sell_avail", 32'(o_available_item), 32'b0111);
      applyStimulus(3'b000, 4'b1000, 1'b0, 1'b0);
      checkOutput("soldout_out", 32'(o_output_item), 32'b0000);
      checkOutput("soldout_bal", 32'(dut.balance_q), 32'd1000);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
      checkOutput("restock_sold", 32'(o_sold_out), 32'b0000);
      checkOutput("restock_stock3", 32'(dut.stock_q[3]), 32'd3);

      // Two selects rising together: lowest available wins.
      applyStimulus(3'b000, 4'b0110, 1'b0, 1'b0);
      checkOutput("multi_sel_out", 32'(o_output_item), 32'b0010);
      checkOutput("multi_sel_bal", 32'(dut.balance_q), 32'd500);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);

      // Coin and vend in the same cycle.
      applyStimulus(3'b001, 4'b0010, 1'b0, 1'b0);
      checkOutput("coinvend_out", 32'(o_output_item), 32'b0010);
      checkOutput("coinvend_bal", 32'(dut.balance_q), 32'd100);
      checkOutput("coinvend_stock1", 32'(dut.stock_q[1]), 32'd1);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);

      // Idle timeout pays out 1600 as 1000, 500, 100.
      resetDut();
      applyStimulus(3'b111, 4'b0000, 1'b0, 1'b0);
      checkOutput("multicoin_bal", 32'(dut.balance_q), 32'd1600);
      cnt = 0;
      while (!o_busy && cnt < 30) begin
         applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
         cnt++;
      end
      checkOutput("timeout_cycles", 32'(cnt), 32'd10);
      checkOutput("timeout_busy", 32'(o_busy), 32'd1);
      checkOutput("timeout_ret0", 32'(o_return_coin), 32'b000);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("to_ret_1000", 32'(o_return_coin), 32'b100);
      checkOutput("to_busy_1", 32'(o_busy), 32'd1);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("to_ret_500", 32'(o_return_coin), 32'b010);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("to_ret_100", 32'(o_return_coin), 32'b001);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("to_ret_done", 32'(o_return_coin), 32'b000);
      checkOutput("to_busy_done", 32'(o_busy), 32'd0);
      checkOutput("to_bal_done", 32'(dut.balance_q), 32'd0);

      // Coin that would exceed the ceiling is echoed back.
      resetDut();
      repeat (9) applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      checkOutput("reject_echo", 32'(o_return_coin), 32'b100);
      checkOutput("reject_bal", 32'(dut.balance_q), 32'd9500);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("reject_clear", 32'(o_return_coin), 32'b000);

      // Return request in IDLE is ignored; in ACCEPT pays out 4800.
      resetDut();
      applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
      checkOutput("idle_trig_busy", 32'(o_busy), 32'd0);
      repeat (4) applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
      repeat (3) applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
      checkOutput("bal_4800", 32'(dut.balance_q), 32'd4800);
      applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
      checkOutput("trig_busy", 32'(o_busy), 32'd1);
      checkOutput("trig_ret0", 32'(o_return_coin), 32'b000);
      expSeq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
      for (int k = 0; k < 8; k++) begin
         if (k == 0) applyStimulus(3'b100, 4'b0001, 1'b0, 1'b0);
         else        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
         checkOutput($sformatf("ret4800_%0d", k), 32'(o_return_coin), 32'(expSeq[k]));
         checkOutput($sformatf("ret4800_out_%0d", k), 32'(o_output_item), 32'd0);
      end
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("ret4800_done", 32'(o_return_coin), 32'b000);
      checkOutput("ret4800_busy", 32'(o_busy), 32'd0);
      checkOutput("ret4800_bal", 32'(dut.balance_q), 32'd0);

      // Reset in the middle of a payout.
      resetDut();
      repeat (3) applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
      applyStimulus(3'b000, 4'b0100, 1'b0, 1'b0);
      checkOutput("pre_vend2", 32'(o_output_item), 32'b0100);
      checkOutput("pre_stock2", 32'(dut.stock_q[2]), 32'd2);
      applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("mid_ret_coin", 32'(o_return_coin), 32'b100);
      reset = 1'b1;
      applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
      checkOutput("midrst_ret", 32'(o_return_coin), 32'b000);
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_bal", 32'(dut.balance_q), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("midrst_stock%0d", i), 32'(dut.stock_q[i]), 32'd3);
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
